// File: rtl/odd_parity_frame_rx_pkg.sv
// Shared constants and state encoding for the odd-parity frame receiver.
package odd_parity_frame_rx_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_W    = DATA_W_DEF + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    STOP  = ST_STOP
  } rx_state_e;

endpackage

// File: rtl/odd_parity_frame_rx_shift_reg.sv
// Right-shift register: new bits enter at the MSB, first bit ends in [0].
module rx_shift_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      data_q <= '0;
    end else if (shift_i) begin
      data_q <= {bit_i, data_q[W-1:1]};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/odd_parity_frame_rx.sv
// Framing receiver: start bit, DATA_W data bits, parity bit, stop bit.
module odd_parity_frame_rx
  import odd_parity_frame_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bit_en,
  input  logic            rx_in,
  output logic [DATA_W:0] frame_out,
  output logic            frame_valid,
  output logic            framing_err,
  output logic            busy
);

  localparam int FW    = DATA_W + 1;
  localparam int CNT_W = $clog2(DATA_W + 2);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             start_clr;
  logic             shift_en;
  logic [FW-1:0]    sreg;

  rx_shift_reg #(
    .W(FW)
  ) u_sreg (
    .clk    (clk),
    .clr_i  (reset | start_clr),
    .shift_i(shift_en),
    .bit_i  (rx_in),
    .data_o (sreg)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    start_clr = 1'b0;
    shift_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bit_en && !rx_in) begin
          cnt_d     = '0;
          start_clr = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          // Parity bit is the last of the DATA_W+1 shifts
          if (cnt_q == CNT_W'(DATA_W)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_en) begin
          state_d = IDLE;
          if (rx_in) begin
            frame_d = sreg;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign frame_out   = frame_q;
  assign frame_valid = valid_q;
  assign framing_err = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_odd_parity_frame_rx.sv
// Scoreboard bench for odd_parity_frame_rx: directed frames, queued results.
module tb_odd_parity_frame_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_en;
  logic       rx_in;
  logic [8:0] frame_out;
  logic       frame_valid;
  logic       framing_err;
  logic       busy;

  typedef struct {
    logic       is_err;
    logic [8:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [8:0] last_good = 9'h000;

  odd_parity_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid || framing_err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b frame=%h, none required",
                 frame_valid, framing_err, frame_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (framing_err !== e.is_err || frame_valid !== !e.is_err ||
            frame_out !== e.frame || busy !== 1'b0) begin
          errors++;
          $display("FAIL pulse: got err=%0b valid=%0b frame=%h busy=%0b, need err=%0b valid=%0b frame=%h busy=0",
                   framing_err, frame_valid, frame_out, busy,
                   e.is_err, !e.is_err, e.frame);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] got,
                     input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, got, want);
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    repeat (gap - 1) @(negedge clk) bit_en = 1'b0;
    @(negedge clk);
    bit_en = 1'b1;
    rx_in  = b;
  endtask

  task automatic quiet(input int n);
    repeat (n) @(negedge clk) begin
      bit_en = 1'b0;
      rx_in  = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stop, input int gaps[11]);
    exp_t e;
    strobe(1'b0, gaps[0]);
    for (int i = 0; i < 8; i++) strobe(d[i], gaps[i+1]);
    strobe(par, gaps[9]);
    e.is_err = !stop;
    if (stop) last_good = {par, d};
    e.frame = last_good;
    exp_q.push_back(e);
    strobe(stop, gaps[10]);
  endtask

  int reg_gaps[11] = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
  int irr_gaps[11] = '{3, 1, 7, 2, 5, 1, 6, 4, 1, 7, 2};

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state", {frame_out, frame_valid, framing_err, busy}, 12'h000);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, 4);
      @(negedge clk);
      bit_en = 1'b0;
      chk("idle_outputs", {frame_out, frame_valid, framing_err, busy}, 12'h000);
    end

    strobe(1'b0, 4);
    @(negedge clk);
    bit_en = 1'b0;
    chk("busy_after_start", {11'h0, busy}, 12'h001);
    for (int i = 0; i < 8; i++) strobe(logic'((8'hA5 >> i) & 1), 4);
    strobe(1'b1, 4);
    last_good = 9'h1A5;
    begin
      exp_t e;
      e.is_err = 1'b0;
      e.frame  = 9'h1A5;
      exp_q.push_back(e);
    end
    strobe(1'b1, 4);
    quiet(3);
    chk("good_a5", {3'b0, frame_out}, 12'h1A5);

    send_frame(8'hA5, 1'b1, 1'b0, reg_gaps);
    quiet(3);
    chk("ferr_keeps", {3'b0, frame_out}, 12'h1A5);

    send_frame(8'h3C, 1'b0, 1'b1, irr_gaps);
    quiet(3);
    chk("gaps_3c", {3'b0, frame_out}, 12'h03C);

    send_frame(8'hFF, 1'b1, 1'b1, reg_gaps);
    quiet(2);
    chk("b2b_first", {3'b0, frame_out}, 12'h1FF);
    send_frame(8'h00, 1'b1, 1'b1, '{2, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4});
    quiet(3);
    chk("b2b_second", {3'b0, frame_out}, 12'h100);

    strobe(1'b0, 4);
    for (int i = 0; i < 4; i++) strobe(logic'((8'h5A >> i) & 1), 4);
    @(negedge clk);
    bit_en = 1'b0;
    chk("busy_mid_frame", {11'h0, busy}, 12'h001);
    reset = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", {11'h0, busy}, 12'h000);
    chk("frame_after_reset", {3'b0, frame_out}, 12'h000);
    reset     = 1'b0;
    last_good = 9'h000;
    quiet(20);

    send_frame(8'h5A, 1'b1, 1'b1, reg_gaps);
    quiet(3);
    chk("after_reset_5a", {3'b0, frame_out}, 12'h15A);
    chk("pending_empty", 12'(exp_q.size()), 12'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
